ictrl_dma_read_to_ibuffer_mb: RTL and testbench
===============================================

Name: ictrl_dma_read_to_ibuffer_mb

Overview:
Multi-bank successor to the single-bank DMA-read-to-ibuffer writer. It accepts a software-configured burst of DMA read beats and writes them into one of BANK_NUM ibuffer banks through a one-entry registered output stage. Beats go either to a selected bank or round-robin interleaved across all banks, starting from a configurable base address. Beats with an all-zero strobe are consumed and counted but not written. It sits between the ictrl DMA read channel and the banked ibuffer SRAMs.

Parameters:
DATA_WIDTH, 128, DMA beat / ibuffer word width
MEM_AW, 15, ibuffer word address width per bank
STRB_WIDTH, DATA_WIDTH/8, byte strobe width
BANK_NUM, 4, number of ibuffer banks; power of 2, at least 2
BANK_W, 2, log2(BANK_NUM)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
cfg_start  input  1  one-cycle start pulse; honoured only in IDLE
cfg_base_addr  input  MEM_AW  first word address
cfg_data_num  input  MEM_AW+1  number of beats in the burst (0 allowed)
cfg_mode  input  1  0 = single bank, 1 = interleave
cfg_bank  input  BANK_W  target bank when cfg_mode=0
busy  output  1  high from the cycle after an accepted start until the cycle after done
dma_rd_data_valid  input  1  DMA beat valid
dma_rd_data  input  DATA_WIDTH  DMA beat data
dma_rd_strb  input  STRB_WIDTH  DMA beat strobe
dma_rd_data_ready  output  1  beat accepted when valid and ready
dma_write_done  output  1  one-cycle pulse when the last beat retires
ibuffer_cen  output  BANK_NUM  one-hot bank write request
ibuffer_wen  output  1  constant 1 (write)
ibuffer_ready  input  BANK_NUM  per-bank ready
ibuffer_addr  output  MEM_AW  word address
ibuffer_wdata  output  DATA_WIDTH  write data
ibuffer_strb  output  STRB_WIDTH  byte strobe

Behaviour:
- Reset values: all outputs 0 except ibuffer_wen=1. State goes to IDLE; counters, stage and config registers clear. A reset mid-burst aborts the burst and produces no done pulse.
- FSM states: IDLE, RUN, DRAIN.
- IDLE, on cfg_start: latch base, num, mode and bank; clear acc_cnt and ret_cnt.
  - num=0: go straight to IDLE-done. dma_write_done pulses the next cycle; busy stays 0.
  - Otherwise go to RUN.
- cfg_start in RUN or DRAIN is ignored.
- RUN:
  - dma_rd_data_ready = (stage empty or stage retiring this cycle) and acc_cnt < num.
  - On a handshake, acc_cnt increments.
  - When acc_cnt reaches num, go to DRAIN.
- IDLE and DRAIN: dma_rd_data_ready = 0.
- Address and bank for beat index i = acc_cnt at acceptance:
  - mode 0: bank = cfg_bank, addr = base + i.
  - mode 1: bank = i[BANK_W-1:0], addr = base + (i >> BANK_W).
  - Address addition wraps modulo 2^MEM_AW.
- Output stage is a one-entry register holding {bank, addr, strb, wdata, skip}, with skip = (strb == 0). Latency: beat accepted in cycle N is presented in cycle N+1.
- Non-skip entry:
  - ibuffer_cen[bank] = 1; all other cen bits are 0.
  - The entry retires when ibuffer_ready[bank] = 1. Other banks' ready bits are ignored.
  - addr, wdata and strb stay stable while cen is high and ready is low.
- Skip entry: cen stays all-zero and the entry retires unconditionally in its first presented cycle.
- Retire bookkeeping: each retire increments ret_cnt. The retire of beat num-1 pulses dma_write_done in that same cycle and moves the FSM to IDLE.
- A retire and a new acceptance in the same cycle are allowed, giving full throughput of 1 beat/cycle.
- busy = (state != IDLE).

Test Plan:
- mode 0, bank 2, base 0x10, num 4, valid held high, all ready high -> cen=4'b0100 at addr 0x10..0x13 on 4 consecutive cycles; done pulses with the 4th write; ready never drops.
- mode 1, base 0x100, num 8 -> banks cycle 0,1,2,3,0,1,2,3 with addr 0x100 ×4 then 0x101 ×4; done on the 8th write.
- mode 0, ibuffer_ready[1] toggles 1/0 on the target bank, others held 0 -> each beat is held stable until ready; dma_rd_data_ready=0 while stage full and not retiring; all 5 beats written in order.
- num 3, 2nd beat strb=0 -> only 2 writes (addr base and base+2); done on the 3rd beat's write. Separately, last beat strb=0 -> done pulses with cen=0.
- Start with num=0 -> done one cycle later; no cen. Base 0x7FFE with num 4 in mode 0 -> addr 0x7FFE, 0x7FFF, 0x0000, 0x0001.
- Assert rst_n low after 2 of 6 beats -> outputs return to reset values and no done pulse. A fresh start then begins at acc_cnt 0. cfg_start during RUN is ignored.

Source files
------------

// File: rtl/ictrl_dma_read_to_ibuffer_mb.sv
`default_nettype none
// ============================================================================
//  Module   : ictrl_dma_read_to_ibuffer_mb
//  Purpose  : Writes a configured burst of DMA read beats into one of several
//             ibuffer banks (single bank or round-robin interleave).
//  Revision : 1.0 - initial multi-bank release
// ============================================================================
module ictrl_dma_read_to_ibuffer_mb #(
  parameter int DATA_WIDTH = 128,
  parameter int MEM_AW     = 15,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int BANK_NUM   = 4,
  parameter int BANK_W     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_start,
  input  logic [MEM_AW-1:0]     cfg_base_addr,
  input  logic [MEM_AW:0]       cfg_data_num,
  input  logic                  cfg_mode,
  input  logic [BANK_W-1:0]     cfg_bank,
  output logic                  busy,
  input  logic                  dma_rd_data_valid,
  input  logic [DATA_WIDTH-1:0] dma_rd_data,
  input  logic [STRB_WIDTH-1:0] dma_rd_strb,
  output logic                  dma_rd_data_ready,
  output logic                  dma_write_done,
  output logic [BANK_NUM-1:0]   ibuffer_cen,
  output logic                  ibuffer_wen,
  input  logic [BANK_NUM-1:0]   ibuffer_ready,
  output logic [MEM_AW-1:0]     ibuffer_addr,
  output logic [DATA_WIDTH-1:0] ibuffer_wdata,
  output logic [STRB_WIDTH-1:0] ibuffer_strb
);

  localparam logic [MEM_AW:0] CNT_ONE = (MEM_AW+1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state, state_nxt;

  logic [MEM_AW-1:0]     base_q;
  logic [MEM_AW:0]       num_q;
  logic                  mode_q;
  logic [BANK_W-1:0]     bank_q;
  logic [MEM_AW:0]       acc_cnt;
  logic [MEM_AW:0]       ret_cnt;
  logic                  zero_done;

  logic                  stg_valid;
  logic                  stg_skip;
  logic [BANK_W-1:0]     stg_bank;
  logic [MEM_AW-1:0]     stg_addr;
  logic [STRB_WIDTH-1:0] stg_strb;
  logic [DATA_WIDTH-1:0] stg_data;

  logic                  start_ok;
  logic                  accept;
  logic                  retire;
  logic                  last_retire;
  logic [MEM_AW-1:0]     beat_off;
  logic [MEM_AW-1:0]     beat_addr;
  logic [BANK_W-1:0]     beat_bank;

  assign start_ok    = (state == IDLE) && cfg_start;
  // Skip entries never wait on a bank; real writes wait only on their own bank.
  assign retire      = stg_valid && (stg_skip || ibuffer_ready[stg_bank]);
  assign last_retire = retire && ((ret_cnt + CNT_ONE) == num_q);
  assign accept      = dma_rd_data_valid && dma_rd_data_ready;

  assign beat_off  = mode_q ? MEM_AW'(acc_cnt >> BANK_W) : acc_cnt[MEM_AW-1:0];
  assign beat_addr = base_q + beat_off;
  assign beat_bank = mode_q ? acc_cnt[BANK_W-1:0] : bank_q;

  assign busy           = (state != IDLE);
  assign dma_write_done = last_retire || zero_done;
  assign ibuffer_wen    = 1'b1;
  assign ibuffer_addr   = stg_addr;
  assign ibuffer_wdata  = stg_data;
  assign ibuffer_strb   = stg_strb;

  always_comb begin
    state_nxt         = state;
    dma_rd_data_ready = 1'b0;
    ibuffer_cen       = '0;
    if (stg_valid && !stg_skip) begin
      ibuffer_cen[stg_bank] = 1'b1;
    end
    case (state)
      IDLE: begin
        if (cfg_start && (cfg_data_num != '0)) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        dma_rd_data_ready = (!stg_valid || retire) && (acc_cnt < num_q);
        if (last_retire) begin
          state_nxt = IDLE;
        end else if (dma_rd_data_valid && dma_rd_data_ready &&
                     ((acc_cnt + CNT_ONE) == num_q)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (last_retire) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      base_q    <= '0;
      num_q     <= '0;
      mode_q    <= 1'b0;
      bank_q    <= '0;
      acc_cnt   <= '0;
      ret_cnt   <= '0;
      zero_done <= 1'b0;
      stg_valid <= 1'b0;
      stg_skip  <= 1'b0;
      stg_bank  <= '0;
      stg_addr  <= '0;
      stg_strb  <= '0;
      stg_data  <= '0;
    end else begin
      state     <= state_nxt;
      // An empty burst completes immediately, one cycle after the start pulse.
      zero_done <= start_ok && (cfg_data_num == '0);
      if (start_ok) begin
        base_q  <= cfg_base_addr;
        num_q   <= cfg_data_num;
        mode_q  <= cfg_mode;
        bank_q  <= cfg_bank;
        acc_cnt <= '0;
        ret_cnt <= '0;
      end else begin
        if (accept) begin
          acc_cnt <= acc_cnt + CNT_ONE;
        end
        if (retire) begin
          ret_cnt <= ret_cnt + CNT_ONE;
        end
      end
      if (accept) begin
        stg_valid <= 1'b1;
        stg_skip  <= (dma_rd_strb == '0);
        stg_bank  <= beat_bank;
        stg_addr  <= beat_addr;
        stg_strb  <= dma_rd_strb;
        stg_data  <= dma_rd_data;
      end else if (retire) begin
        stg_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ictrl_dma_read_to_ibuffer_mb.sv
`default_nettype none
// Bench for ictrl_dma_read_to_ibuffer_mb: directed scenarios plus random bursts
// compared against a queue of expected bank writes built from the burst config.
module tb_ictrl_dma_read_to_ibuffer_mb;
  localparam int DW = 128;
  localparam int AW = 15;
  localparam int SW = DW / 8;
  localparam int BN = 4;
  localparam int BW = 2;
  localparam int BUDGET = 400;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_start;
  logic [AW-1:0] cfg_base_addr;
  logic [AW:0]   cfg_data_num;
  logic          cfg_mode;
  logic [BW-1:0] cfg_bank;
  logic          busy;
  logic          dma_rd_data_valid;
  logic [DW-1:0] dma_rd_data;
  logic [SW-1:0] dma_rd_strb;
  logic          dma_rd_data_ready;
  logic          dma_write_done;
  logic [BN-1:0] ibuffer_cen;
  logic          ibuffer_wen;
  logic [BN-1:0] ibuffer_ready;
  logic [AW-1:0] ibuffer_addr;
  logic [DW-1:0] ibuffer_wdata;
  logic [SW-1:0] ibuffer_strb;

  always #5 clk = ~clk;

  ictrl_dma_read_to_ibuffer_mb #(
    .DATA_WIDTH(DW), .MEM_AW(AW), .STRB_WIDTH(SW), .BANK_NUM(BN), .BANK_W(BW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
    .cfg_data_num(cfg_data_num), .cfg_mode(cfg_mode), .cfg_bank(cfg_bank), .busy(busy),
    .dma_rd_data_valid(dma_rd_data_valid), .dma_rd_data(dma_rd_data),
    .dma_rd_strb(dma_rd_strb), .dma_rd_data_ready(dma_rd_data_ready),
    .dma_write_done(dma_write_done), .ibuffer_cen(ibuffer_cen), .ibuffer_wen(ibuffer_wen),
    .ibuffer_ready(ibuffer_ready), .ibuffer_addr(ibuffer_addr),
    .ibuffer_wdata(ibuffer_wdata), .ibuffer_strb(ibuffer_strb)
  );

  typedef struct {
    logic [BW-1:0] bank;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic reset_checks();
    check("rst_cen", ibuffer_cen, 0);
    check("rst_wen", ibuffer_wen, 1);
    check("rst_addr", ibuffer_addr, 0);
    check("rst_wdata", ibuffer_wdata, 0);
    check("rst_strb", ibuffer_strb, 0);
    check("rst_busy", busy, 0);
    check("rst_done", dma_write_done, 0);
    check("rst_ready", dma_rd_data_ready, 0);
  endtask

  // strb_pat: 0 all nonzero, 1 random with zeros, 2 beat 1 zero, 3 last beat zero
  // rdy_pat : 0 all banks ready, 1 random, 2 only target bank toggling
  task automatic run_burst(input logic [AW-1:0] base, input int num, input logic mode,
                           input logic [BW-1:0] bank, input int strb_pat, input int rdy_pat,
                           input bit vld_rand, input int abort_after, input bit poke_start);
    logic [DW-1:0] bdata[$];
    logic [SW-1:0] bstrb[$];
    int  k = 0;
    int  last_acc = -10;
    bit  done_seen = 0;
    bit  last_nonskip;
    bit  popped_last;
    bit  exp_done;
    bit  latency_due = 0;
    exp_q.delete();
    for (int i = 0; i < num; i++) begin
      logic [SW-1:0] s;
      wr_t w;
      s = SW'($urandom_range(1, 65535));
      if (strb_pat == 1 && $urandom_range(0, 3) == 0) s = '0;
      if (strb_pat == 2 && i == 1) s = '0;
      if (strb_pat == 3 && i == num - 1) s = '0;
      bdata.push_back(rand_data());
      bstrb.push_back(s);
      if (s != '0) begin
        w.bank = mode ? BW'(i % BN) : bank;
        w.addr = base + AW'(mode ? i / BN : i);
        w.data = bdata[i];
        w.strb = s;
        exp_q.push_back(w);
      end
    end
    last_nonskip = (num > 0) && (bstrb[num-1] != '0);

    cfg_base_addr = base;
    cfg_data_num  = (AW+1)'(num);
    cfg_mode      = mode;
    cfg_bank      = bank;
    cfg_start     = 1'b1;
    @(posedge clk); #1;
    cfg_start     = 1'b0;
    cfg_base_addr = AW'($urandom);
    cfg_bank      = BW'($urandom);

    for (int cyc = 1; cyc <= BUDGET && !done_seen; cyc++) begin
      dma_rd_data_valid = vld_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      dma_rd_data = (k < num) ? bdata[k] : rand_data();
      dma_rd_strb = (k < num) ? bstrb[k] : SW'($urandom);
      case (rdy_pat)
        0: ibuffer_ready = '1;
        1: ibuffer_ready = BN'($urandom_range(0, 15));
        default: begin
          ibuffer_ready = '0;
          ibuffer_ready[bank] = cyc[0];
        end
      endcase
      if (poke_start && cyc == 2) begin
        cfg_start    = 1'b1;
        cfg_data_num = (AW+1)'(3);
        cfg_mode     = ~mode;
      end
      @(negedge clk);
      popped_last = 0;
      check("busy", busy, num > 0);
      if (ibuffer_cen != '0) begin
        check("cen_onehot", $onehot(ibuffer_cen), 1);
        if (exp_q.size() == 0) begin
          check("unexpected_write", ibuffer_cen, 0);
        end else begin
          wr_t w;
          w = exp_q[0];
          check("cen", ibuffer_cen, BN'(1) << w.bank);
          check("addr", ibuffer_addr, w.addr);
          check("wdata", ibuffer_wdata, w.data);
          check("strb", ibuffer_strb, w.strb);
          if (ibuffer_ready[w.bank]) begin
            void'(exp_q.pop_front());
            popped_last = (exp_q.size() == 0);
          end else begin
            check("stall_ready", dma_rd_data_ready, 0);
          end
        end
      end
      if (latency_due) check("latency", ibuffer_cen != '0, 1);
      latency_due = 0;
      exp_done = (num == 0) ? (cyc == 1)
               : (k == num && (last_nonskip ? popped_last : (cyc == last_acc + 1)));
      check("done", dma_write_done, exp_done);
      if (dma_write_done) done_seen = 1;
      if (rdy_pat == 0 && !vld_rand && cyc <= num) check("full_rate_ready", dma_rd_data_ready, 1);
      if (k >= num) check("ready_after_num", dma_rd_data_ready, 0);
      if (dma_rd_data_valid && dma_rd_data_ready && k < num) begin
        if (bstrb[k] != '0) latency_due = 1;
        if (k == num - 1) last_acc = cyc;
        k++;
      end
      if (abort_after >= 0 && k == abort_after) begin
        @(posedge clk); #1;
        dma_rd_data_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        reset_checks();
        repeat (2) begin
          @(negedge clk);
          check("abort_no_done", dma_write_done, 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
      cfg_start = 1'b0;
    end
    if (!done_seen) check("done_timeout", 0, 1);
    dma_rd_data_valid = 1'b0;
    @(negedge clk);
    check("busy_after", busy, 0);
    check("cen_after", ibuffer_cen, 0);
    check("all_written", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_start = 1'b0;
    cfg_base_addr = '0;
    cfg_data_num = '0;
    cfg_mode = 1'b0;
    cfg_bank = '0;
    dma_rd_data_valid = 1'b0;
    dma_rd_data = '0;
    dma_rd_strb = '0;
    ibuffer_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_burst(15'h0010, 4, 1'b0, 2'd2, 0, 0, 1'b0, -1, 1'b0);
    run_burst(15'h0100, 8, 1'b1, 2'd0, 0, 0, 1'b0, -1, 1'b0);
    run_burst(15'h0020, 5, 1'b0, 2'd1, 0, 2, 1'b0, -1, 1'b0);
    run_burst(15'h0040, 3, 1'b0, 2'd3, 2, 0, 1'b0, -1, 1'b0);
    run_burst(15'h0050, 4, 1'b1, 2'd0, 3, 0, 1'b0, -1, 1'b0);
    run_burst(15'h0060, 0, 1'b0, 2'd0, 0, 0, 1'b0, -1, 1'b0);
    run_burst(15'h7FFE, 4, 1'b0, 2'd1, 0, 0, 1'b0, -1, 1'b0);
    run_burst(15'h0200, 6, 1'b1, 2'd0, 0, 0, 1'b0, 2, 1'b0);
    run_burst(15'h0200, 6, 1'b1, 2'd0, 0, 0, 1'b0, -1, 1'b1);
    for (int t = 0; t < 25; t++) begin
      run_burst(AW'($urandom), $urandom_range(0, 20), 1'($urandom), BW'($urandom),
                1, 1, 1'b1, -1, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
